// File: rtl/interp_pkg.sv
// Shared definitions for the fractional interpolation tap-sum stage.
//
// Contents:
//   N_TAPS     number of filter taps feeding the sum stage
//   FRAC_W     width of the fractional-position sideband
//   COEF_SHIFT log2 of the coefficient-set sum (every set sums to 64)
//   ACC_W      width used by the round/clip helpers
//   OUT_EXTRA  extra output bits when clipping is disabled
//   round_shift()   round-half-up then arithmetic shift right
//   clip_unsigned() clamp a signed value into [0, 2^bit_depth-1]
//
// Configuration macro: INTERP_TAP_SUM_CLIP_EN
//   defined     -> output is clipped to BIT_DEPTH unsigned bits
//   not defined -> output is BIT_DEPTH+2 signed bits, no clipping
package interp_pkg;

    localparam int unsigned N_TAPS     = 8;
    localparam int unsigned FRAC_W     = 4;
    localparam int unsigned COEF_SHIFT = 6;
    localparam int unsigned ACC_W      = 64;

`ifdef INTERP_TAP_SUM_CLIP_EN
    localparam int unsigned OUT_EXTRA = 0;
`else
    localparam int unsigned OUT_EXTRA = 2;
`endif

    // (sum + 2^(shift-1)) >>> shift; floors toward -inf for negatives. shift must be >= 1.
    function automatic logic signed [ACC_W-1:0] round_shift(
        input logic signed [ACC_W-1:0] sum,
        input int unsigned             shift
    );
        logic signed [ACC_W-1:0] half;
        half = 64'sd1 <<< (shift - 1);
        return (sum + half) >>> shift;
    endfunction

    function automatic logic [ACC_W-1:0] clip_unsigned(
        input logic signed [ACC_W-1:0] v,
        input int unsigned             bit_depth
    );
        logic signed [ACC_W-1:0] maxv;
        maxv = (64'sd1 <<< bit_depth) - 64'sd1;
        if (v < 64'sd0) begin
            return '0;
        end else if (v > maxv) begin
            return maxv;
        end else begin
            return v;
        end
    endfunction

endpackage

// File: rtl/interp_add_tree.sv
// One combinational level of the pairwise adder tree.
//
// Sums adjacent lanes: dout lane i = din lane 2i + din lane 2i+1. Lanes are already
// sign-extended wide enough by the caller, so a plain modular add is exact.
//
// Parameters:
//   N_IN  number of input lanes (even)
//   W     lane width
// Ports:
//   din   in   N_IN*W      packed input lanes, lane k at [k*W +: W]
//   dout  out  N_IN/2*W    packed pairwise sums
module interp_add_tree #(
    parameter int unsigned N_IN = 8,
    parameter int unsigned W    = 35
) (
    input  logic [N_IN*W-1:0]     din,
    output logic [(N_IN/2)*W-1:0] dout
);

    for (genvar i = 0; i < N_IN / 2; i++) begin : g_pair
        assign dout[i*W +: W] = din[(2*i)*W +: W] + din[(2*i+1)*W +: W];
    end

endmodule

// File: rtl/interp_tap_sum.sv
// Downstream sum stage of the 8-tap interpolation filter.
//
// Adds the eight per-tap products of one fractional position through a 3-stage
// pipeline (8->4 | 4->2->1 | round/shift/clip), and emits one sample per accepted
// input with valid/ready on both sides. All stages share one enable, so a stalled
// output freezes the whole pipe and bubbles stay in place.
//
// Ports:
//   clk         in   1                     rising-edge clock
//   rst_n       in   1                     synchronous reset, active low
//   in_valid    in   1                     product set valid
//   in_ready    out  1                     stage can accept (combinational)
//   in_prod     in   8*W_PROD              signed products, tap k at [k*W_PROD +: W_PROD]
//   in_frac     in   4                     fractional position sideband
//   out_valid   out  1                     out_sample valid
//   out_ready   in   1                     consumer accepts
//   out_sample  out  BIT_DEPTH(+2)         interpolated sample
//   out_frac    out  4                     in_frac of the same transfer
//   out_last    out  1                     last sample of a row of ROW_LEN
//
// Configuration macro: INTERP_TAP_SUM_CLIP_EN
//   defined     -> out_sample is BIT_DEPTH bits, clipped to [0, 2^BIT_DEPTH-1]
//   not defined -> out_sample is BIT_DEPTH+2 bits, signed, unclipped
module interp_tap_sum
    import interp_pkg::*;
#(
    parameter int unsigned W_PROD    = 32,
    parameter int unsigned SHIFT     = COEF_SHIFT,
    parameter int unsigned BIT_DEPTH = 10,
    parameter int unsigned ROW_LEN   = 16
) (
    input  logic                            clk,
    input  logic                            rst_n,
    input  logic                            in_valid,
    output logic                            in_ready,
    input  logic [N_TAPS*W_PROD-1:0]        in_prod,
    input  logic [FRAC_W-1:0]               in_frac,
    output logic                            out_valid,
    input  logic                            out_ready,
    output logic [BIT_DEPTH+OUT_EXTRA-1:0]  out_sample,
    output logic [FRAC_W-1:0]               out_frac,
    output logic                            out_last
);

    // Three guard bits cover the growth of an 8-input sum.
    localparam int unsigned SUM_W = W_PROD + 3;
    localparam int unsigned OUT_W = BIT_DEPTH + OUT_EXTRA;
    localparam int unsigned CNT_W = (ROW_LEN > 1) ? $clog2(ROW_LEN) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(ROW_LEN - 1);

    logic en;

    logic [N_TAPS*SUM_W-1:0]     prod_ext;
    logic [(N_TAPS/2)*SUM_W-1:0] l0_sum;
    logic [(N_TAPS/4)*SUM_W-1:0] l1_sum;
    logic [SUM_W-1:0]            l2_sum;

    logic                        s1_valid_q;
    logic [(N_TAPS/2)*SUM_W-1:0] s1_sum_q;
    logic [FRAC_W-1:0]           s1_frac_q;

    logic                        s2_valid_q;
    logic signed [SUM_W-1:0]     s2_sum_q;
    logic [FRAC_W-1:0]           s2_frac_q;

    logic                        out_valid_q;
    logic [OUT_W-1:0]            out_sample_q;
    logic [FRAC_W-1:0]           out_frac_q;

    logic [CNT_W-1:0]            row_cnt_q;
    logic [CNT_W-1:0]            row_cnt_d;

    logic signed [ACC_W-1:0]     sum_ext;
    logic signed [ACC_W-1:0]     rnd;
    logic [OUT_W-1:0]            sample_d;

    // Handshake: the whole pipe moves whenever the output register is free or draining.
    assign en        = !out_valid_q || out_ready;
    assign in_ready  = en;
    assign out_valid = out_valid_q;
    assign out_sample = out_sample_q;
    assign out_frac  = out_frac_q;
    // Gated by out_valid so reset and idle show 0 even when ROW_LEN == 1.
    assign out_last  = out_valid_q && (row_cnt_q == CNT_LAST);

    for (genvar k = 0; k < N_TAPS; k++) begin : g_ext
        assign prod_ext[k*SUM_W +: SUM_W] =
            {{(SUM_W - W_PROD){in_prod[k*W_PROD + W_PROD - 1]}}, in_prod[k*W_PROD +: W_PROD]};
    end

    interp_add_tree #(
        .N_IN (N_TAPS),
        .W    (SUM_W)
    ) u_add_l0 (
        .din  (prod_ext),
        .dout (l0_sum)
    );

    interp_add_tree #(
        .N_IN (N_TAPS / 2),
        .W    (SUM_W)
    ) u_add_l1 (
        .din  (s1_sum_q),
        .dout (l1_sum)
    );

    interp_add_tree #(
        .N_IN (N_TAPS / 4),
        .W    (SUM_W)
    ) u_add_l2 (
        .din  (l1_sum),
        .dout (l2_sum)
    );

    assign sum_ext = {{(ACC_W - SUM_W){s2_sum_q[SUM_W-1]}}, s2_sum_q};
    assign rnd     = round_shift(sum_ext, SHIFT);

`ifdef INTERP_TAP_SUM_CLIP_EN
    logic [ACC_W-1:0] clipped;
    logic             unused_clip_hi;
    assign clipped        = clip_unsigned(rnd, BIT_DEPTH);
    assign sample_d       = clipped[OUT_W-1:0];
    assign unused_clip_hi = ^clipped[ACC_W-1:OUT_W];
`else
    // Low bits only: the first 2-D pass keeps a signed value with two headroom bits.
    logic unused_rnd_hi;
    assign sample_d      = rnd[OUT_W-1:0];
    assign unused_rnd_hi = ^rnd[ACC_W-1:OUT_W];
`endif

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            s1_valid_q   <= 1'b0;
            s1_sum_q     <= '0;
            s1_frac_q    <= '0;
            s2_valid_q   <= 1'b0;
            s2_sum_q     <= '0;
            s2_frac_q    <= '0;
            out_valid_q  <= 1'b0;
            out_sample_q <= '0;
            out_frac_q   <= '0;
        end else if (en) begin
            s1_valid_q  <= in_valid;
            s2_valid_q  <= s1_valid_q;
            out_valid_q <= s2_valid_q;
            if (in_valid) begin
                s1_sum_q  <= l0_sum;
                s1_frac_q <= in_frac;
            end
            if (s1_valid_q) begin
                s2_sum_q  <= l2_sum;
                s2_frac_q <= s1_frac_q;
            end
            // Reloads in the same cycle the previous sample drains: no bubble inserted.
            if (s2_valid_q) begin
                out_sample_q <= sample_d;
                out_frac_q   <= s2_frac_q;
            end
        end
    end

    always_comb begin
        row_cnt_d = row_cnt_q;
        if (out_valid_q && out_ready) begin
            if (row_cnt_q == CNT_LAST) begin
                row_cnt_d = '0;
            end else begin
                row_cnt_d = row_cnt_q + CNT_W'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            row_cnt_q <= '0;
        end else begin
            row_cnt_q <= row_cnt_d;
        end
    end

endmodule

// File: tb/tb_interp_tap_sum.sv
module tb_interp_tap_sum;

    localparam int unsigned W_PROD    = 32;
    localparam int unsigned SHIFT     = 6;
    localparam int unsigned BIT_DEPTH = 10;
    localparam int unsigned ROW_LEN   = 4;
`ifdef INTERP_TAP_SUM_CLIP_EN
    localparam int unsigned OUT_W = BIT_DEPTH;
`else
    localparam int unsigned OUT_W = BIT_DEPTH + 2;
`endif

    logic                  clk = 1'b0;
    logic                  rst_n;
    logic                  in_valid;
    logic                  in_ready;
    logic [8*W_PROD-1:0]   in_prod;
    logic [3:0]            in_frac;
    logic                  out_valid;
    logic                  out_ready;
    logic [OUT_W-1:0]      out_sample;
    logic [3:0]            out_frac;
    logic                  out_last;

    always #5 clk = ~clk;

    interp_tap_sum #(
        .W_PROD    (W_PROD),
        .SHIFT     (SHIFT),
        .BIT_DEPTH (BIT_DEPTH),
        .ROW_LEN   (ROW_LEN)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_prod    (in_prod),
        .in_frac    (in_frac),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_sample (out_sample),
        .out_frac   (out_frac),
        .out_last   (out_last)
    );

    typedef struct {
        logic [63:0] sample;
        logic [3:0]  frac;
    } exp_t;

    int          total = 0;
    int          bad   = 0;
    exp_t        q[$];
    int          n_out;       // outputs since last reset
    int          n_phase;     // outputs counted within one test phase
    logic [31:0] last_mask;   // bit i set when output i carried out_last
    int          taps[8];
    logic        accepted;

    task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", tag, got, got, exp, exp);
        end
    endtask

    // Reference: integer sum, round-half-up division with floor, then clip or truncate.
    function automatic logic [63:0] model_sample(input int t[8]);
        longint s;
        longint num;
        longint den;
        longint r;
        longint lim;
        s = 0;
        for (int i = 0; i < 8; i++) s += longint'(t[i]);
        den = longint'(2) ** SHIFT;
        num = s + den / 2;
        r = num / den;
        if ((num % den != 0) && (num < 0)) r = r - 1;
`ifdef INTERP_TAP_SUM_CLIP_EN
        lim = (longint'(2) ** BIT_DEPTH) - 1;
        if (r < 0) r = 0;
        else if (r > lim) r = lim;
        return 64'(r);
`else
        lim = longint'(2) ** OUT_W;
        return 64'(r) & 64'(lim - 1);
`endif
    endfunction

    function automatic logic [8*W_PROD-1:0] pack(input int t[8]);
        logic [8*W_PROD-1:0] p;
        for (int k = 0; k < 8; k++) p[k*W_PROD +: W_PROD] = t[k];
        return p;
    endfunction

    // One clock: drive at negedge, then check what will happen at the coming posedge.
    task automatic step(input logic v, input logic [3:0] f, input logic ordy);
        exp_t e;
        @(negedge clk);
        in_valid  = v;
        in_frac   = f;
        in_prod   = pack(taps);
        out_ready = ordy;
        #1;
        accepted = 1'b0;
        check_val("in_ready", 64'(in_ready), 64'(!out_valid || out_ready));
        if (out_valid) begin
            if (q.size() == 0) begin
                check_val("spurious_out", 64'(out_valid), 64'd0);
            end else begin
                e = q[0];
                check_val("sample", 64'(out_sample), e.sample);
                check_val("frac", 64'(out_frac), 64'(e.frac));
                check_val("last", 64'(out_last), 64'((n_out % ROW_LEN) == ROW_LEN - 1));
                if (out_ready) begin
                    void'(q.pop_front());
                    if (out_last && n_out < 32) last_mask[n_out] = 1'b1;
                    n_out++;
                    n_phase++;
                end
            end
        end
        if (v && in_ready) begin
            e.sample = model_sample(taps);
            e.frac   = f;
            q.push_back(e);
            accepted = 1'b1;
        end
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst_n     = 1'b0;
        in_valid  = 1'b0;
        out_ready = 1'b1;
        @(negedge clk);
        rst_n = 1'b1;
        q.delete();
        n_out     = 0;
        last_mask = '0;
        #1;
        check_val("rst_out_valid", 64'(out_valid), 64'd0);
        check_val("rst_out_sample", 64'(out_sample), 64'd0);
        check_val("rst_out_frac", 64'(out_frac), 64'd0);
        check_val("rst_out_last", 64'(out_last), 64'd0);
    endtask

    task automatic drain();
        for (int i = 0; i < 40 && q.size() != 0; i++) step(1'b0, 4'd0, 1'b1);
        check_val("drain_empty", 64'(q.size()), 64'd0);
    endtask

    task automatic rand_taps();
        for (int k = 0; k < 8; k++) taps[k] = int'($urandom_range(40000)) - 12000;
    endtask

    task automatic set_single(input int v);
        for (int k = 0; k < 8; k++) taps[k] = 0;
        taps[3] = v;
    endtask

    initial begin
        int coef[8];
        int sums[6];
        rst_n     = 1'b0;
        in_valid  = 1'b0;
        in_prod   = '0;
        in_frac   = '0;
        out_ready = 1'b1;
        n_out     = 0;
        n_phase   = 0;
        last_mask = '0;
        for (int k = 0; k < 8; k++) taps[k] = 0;
        do_reset();

        // Directed 100*[0,1,-3,63,4,-2,1,0], latency check.
        coef = '{0, 1, -3, 63, 4, -2, 1, 0};
        for (int k = 0; k < 8; k++) taps[k] = 100 * coef[k];
        step(1'b1, 4'd1, 1'b1);
        check_val("acc_first", 64'(accepted), 64'd1);
        step(1'b0, 4'd0, 1'b1);
        check_val("lat_c1", 64'(out_valid), 64'd0);
        step(1'b0, 4'd0, 1'b1);
        check_val("lat_c2", 64'(out_valid), 64'd0);
        step(1'b0, 4'd0, 1'b1);
        check_val("lat_c3", 64'(out_valid), 64'd1);
        check_val("t1_sample", 64'(out_sample), 64'd100);
        check_val("t1_frac", 64'(out_frac), 64'd1);
        drain();

        // Arithmetic boundaries, back to back.
        sums = '{-640, 64 * 1200, 95, 64 * 1023 + 31, 64 * 1023 + 32, -33};
        for (int i = 0; i < 6; i++) begin
            set_single(sums[i]);
            step(1'b1, 4'(i + 2), 1'b1);
        end
        drain();

        // Five inputs with a 4-cycle output stall in the middle.
        do_reset();
        n_phase = 0;
        for (int i = 0, cyc = 0; i < 5; i++) begin
            rand_taps();
            accepted = 1'b0;
            for (int t = 0; t < 20 && !accepted; t++) begin
                step(1'b1, 4'(i + 7), !(cyc >= 3 && cyc < 7));
                cyc++;
            end
            check_val("stall_accept", 64'(accepted), 64'd1);
        end
        drain();
        check_val("stall_count", 64'(n_phase), 64'd5);

        // Row cadence: 9 back-to-back transfers after reset.
        do_reset();
        n_phase = 0;
        for (int i = 0; i < 9; i++) begin
            rand_taps();
            step(1'b1, 4'(i), 1'b1);
        end
        drain();
        check_val("row_count", 64'(n_phase), 64'd9);
        check_val("row_last_mask", 64'(last_mask[8:0]), 64'b010001000);

        // Reset with two samples in flight after one completed output.
        rand_taps();
        step(1'b1, 4'd5, 1'b1);
        drain();
        rand_taps();
        step(1'b1, 4'd6, 1'b1);
        rand_taps();
        step(1'b1, 4'd7, 1'b1);
        do_reset();
        for (int i = 0; i < 6; i++) step(1'b0, 4'd0, 1'b1);
        n_phase = 0;
        for (int i = 0; i < 4; i++) begin
            rand_taps();
            step(1'b1, 4'(i + 1), 1'b1);
        end
        drain();
        check_val("post_rst_count", 64'(n_phase), 64'd4);
        check_val("post_rst_last_mask", 64'(last_mask[3:0]), 64'b1000);

        // Random traffic with random backpressure.
        for (int i = 0; i < 300; i++) begin
            rand_taps();
            step(1'($urandom_range(1)), 4'($urandom_range(15)), 1'($urandom_range(3) != 0));
        end
        drain();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: got no finish, required finish before 200000");
        $fatal(1, "timeout");
    end

endmodule
